// File: rtl/buzzer_tone_seq.sv
// Note sequencer feeding the buzzer PWM stage: buffers {code, oct, ms} notes in a FIFO
// and plays each one as a phase increment/threshold pair, followed by a fixed silent gap.
module buzzer_tone_seq #(
    parameter int CLKS_PER_MS = 50000,
    parameter int GAP_MS      = 10,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [3:0]  note_code,
    input  logic [1:0]  note_oct,
    input  logic [11:0] note_ms,
    output logic [31:0] period,
    output logic [31:0] duty,
    output logic        busy,
    output logic        note_done
);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [11:0]   GAP_LAST = 12'(GAP_MS - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]   DUTY_HALF   = 32'h8000_0000;
    localparam logic [31:0]   DUTY_SILENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t         state_q, state_d;
    logic [17:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [3:0]     code_q, code_d;
    logic [1:0]     oct_q, oct_d;
    logic [11:0]    ms_q, ms_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [11:0]    ms_cnt_q, ms_cnt_d;
    logic [31:0]    period_q, period_d;
    logic [31:0]    duty_q, duty_d;
    logic           note_ready_q, note_ready_d;
    logic           busy_q, busy_d;
    logic           note_done_q, note_done_d;

    logic           push, pop, last_pre, play_last, gap_last;
    logic [17:0]    head;
    logic [15:0]    base_inc;
    logic [31:0]    tone_inc;

    assign push      = note_valid && note_ready_q && !stop;
    assign pop       = (state_q == LOAD) && !stop;
    assign head      = mem_q[rd_ptr_q];
    assign last_pre  = (pre_q == PRE_LAST);
    assign play_last = last_pre && (ms_cnt_q == ms_q - 12'd1);
    assign gap_last  = last_pre && (ms_cnt_q == GAP_LAST);

    // Increments are 2^32 / 50 MHz scaled note frequencies; zero marks a rest.
    always_comb begin
        base_inc = 16'd0;
        case (code_q)
            4'd1:    base_inc = 16'd22474;
            4'd2:    base_inc = 16'd25225;
            4'd3:    base_inc = 16'd28315;
            4'd4:    base_inc = 16'd29999;
            4'd5:    base_inc = 16'd33673;
            4'd6:    base_inc = 16'd37796;
            4'd7:    base_inc = 16'd42424;
            4'd8:    base_inc = 16'd44947;
            default: base_inc = 16'd0;
        endcase
        tone_inc = {16'd0, base_inc} << oct_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        if (stop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        oct_d       = oct_q;
        ms_d        = ms_q;
        pre_d       = pre_q;
        ms_cnt_d    = ms_cnt_q;
        note_done_d = 1'b0;
        period_d    = 32'd0;
        duty_d      = DUTY_SILENT;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                code_d   = head[17:14];
                oct_d    = head[13:12];
                ms_d     = head[11:0];
                pre_d    = '0;
                ms_cnt_d = '0;
                if (head[11:0] == 12'd0) begin
                    note_done_d = 1'b1;
                    state_d     = (count_q > CNT_ONE) ? LOAD : IDLE;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (base_inc != 16'd0) begin
                    period_d = tone_inc;
                    duty_d   = DUTY_HALF;
                end
                pre_d = last_pre ? '0 : pre_q + PW'(1);
                if (last_pre) ms_cnt_d = ms_cnt_q + 12'd1;
                if (play_last) begin
                    pre_d    = '0;
                    ms_cnt_d = '0;
                    if (GAP_MS == 0) begin
                        note_done_d = 1'b1;
                        state_d     = (count_q != '0) ? LOAD : IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                pre_d = last_pre ? '0 : pre_q + PW'(1);
                if (last_pre) ms_cnt_d = ms_cnt_q + 12'd1;
                if (gap_last) begin
                    note_done_d = 1'b1;
                    state_d     = (count_q != '0) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d     = IDLE;
            note_done_d = 1'b0;
            period_d    = 32'd0;
            duty_d      = DUTY_SILENT;
        end
        note_ready_d = (count_d != CNT_FULL);
        busy_d       = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {note_code, note_oct, note_ms};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            code_q       <= '0;
            oct_q        <= '0;
            ms_q         <= '0;
            pre_q        <= '0;
            ms_cnt_q     <= '0;
            period_q     <= 32'd0;
            duty_q       <= DUTY_SILENT;
            note_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            note_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            code_q       <= code_d;
            oct_q        <= oct_d;
            ms_q         <= ms_d;
            pre_q        <= pre_d;
            ms_cnt_q     <= ms_cnt_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            note_ready_q <= note_ready_d;
            busy_q       <= busy_d;
            note_done_q  <= note_done_d;
        end
    end

    assign note_ready = note_ready_q;
    assign period     = period_q;
    assign duty       = duty_q;
    assign busy       = busy_q;
    assign note_done  = note_done_q;
endmodule
